// File: rtl/fir_pkg.sv
// Shared types and helpers for the serial polyphase interpolating FIR.
// Covers accumulator sizing, output scaling and the controller state encoding.
package fir_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StMac,
        StOut
    } interp_state_t;

    // Accumulator width: full product plus growth for `taps` additions, at least one guard bit.
    function automatic int unsigned acc_width(input int unsigned in_w,
                                              input int unsigned coef_w,
                                              input int unsigned taps);
        int unsigned grow;
        grow = $clog2(taps);
        if (grow < 1) begin
            grow = 1;
        end
        return in_w + coef_w + grow;
    endfunction

    // Keeps the top out_w bits of an acc_w-bit value (truncating LSBs), or sign-extends when
    // the output is wider. The caller narrows the 64-bit result to out_w bits.
    function automatic logic signed [63:0] scale_out(input logic signed [63:0] acc,
                                                     input int unsigned acc_w,
                                                     input int unsigned out_w);
        if (out_w <= acc_w) begin
            return acc >>> (acc_w - out_w);
        end
        return acc;
    endfunction

endpackage

// File: rtl/fir_mac_unit.sv
// Signed multiply-accumulate with synchronous clear and enable.
// acc_sum is the combinational running sum including the current product.
module fir_mac_unit #(
    parameter int unsigned INPUT_WIDTH = 16,
    parameter int unsigned COEFF_WIDTH = 8,
    parameter int unsigned ACC_WIDTH   = 25
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          clr,
    input  logic                          en,
    input  logic signed [INPUT_WIDTH-1:0] x,
    input  logic signed [COEFF_WIDTH-1:0] h,
    output logic signed [ACC_WIDTH-1:0]   acc_sum
);

    localparam int unsigned PROD_WIDTH = INPUT_WIDTH + COEFF_WIDTH;

    logic signed [PROD_WIDTH-1:0] prod;
    logic signed [ACC_WIDTH-1:0]  acc_q;

    assign prod    = PROD_WIDTH'(x) * PROD_WIDTH'(h);
    assign acc_sum = acc_q + ACC_WIDTH'(prod);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
        end else if (clr) begin
            acc_q <= '0;
        end else if (en) begin
            acc_q <= acc_sum;
        end
    end

endmodule

// File: rtl/fir_interpolator_serial.sv
// Polyphase interpolating FIR: one input sample yields INTERP outputs, each computed
// over P = NUM_TAPS/INTERP taps on a single time-multiplexed MAC.
module fir_interpolator_serial
    import fir_pkg::*;
#(
    parameter int unsigned INPUT_WIDTH  = 16,
    parameter int unsigned COEFF_WIDTH  = 8,
    parameter int unsigned OUTPUT_WIDTH = 25,
    parameter int unsigned INTERP       = 4,
    parameter int unsigned NUM_TAPS     = 36,
    parameter logic signed [COEFF_WIDTH-1:0] COEFFS [NUM_TAPS] = '{
        -8'sd1, -8'sd2, -8'sd3, -8'sd2, 8'sd0, 8'sd4, 8'sd9, 8'sd15, 8'sd22,
        8'sd30, 8'sd38, 8'sd46, 8'sd54, 8'sd61, 8'sd66, 8'sd70, 8'sd72, 8'sd73,
        8'sd73, 8'sd72, 8'sd70, 8'sd66, 8'sd61, 8'sd54, 8'sd46, 8'sd38, 8'sd30,
        8'sd22, 8'sd15, 8'sd9, 8'sd4, 8'sd0, -8'sd2, -8'sd3, -8'sd2, -8'sd1
    }
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           valid_in,
    output logic                           ready_in,
    input  logic signed [INPUT_WIDTH-1:0]  din,
    output logic                           valid_out,
    input  logic                           ready_out,
    output logic signed [OUTPUT_WIDTH-1:0] dout
);

    localparam int unsigned P         = NUM_TAPS / INTERP;
    localparam int unsigned ACC_WIDTH = acc_width(INPUT_WIDTH, COEFF_WIDTH, P);
    localparam int unsigned TAP_W     = (P > 1) ? $clog2(P) : 1;
    localparam int unsigned PH_W      = $clog2(INTERP);
    localparam int unsigned IDX_W     = $clog2(NUM_TAPS);

    interp_state_t state_q, state_d;

    logic signed [INPUT_WIDTH-1:0]  x_q [P];
    logic [TAP_W-1:0]               tap_q, tap_d;
    logic [PH_W-1:0]                phase_q, phase_d;
    logic signed [OUTPUT_WIDTH-1:0] dout_q, dout_d;
    logic                           valid_q, valid_d;

    logic                           shift_en;
    logic                           mac_clr;
    logic                           mac_en;
    logic [31:0]                    coef_sum;
    logic [IDX_W-1:0]               coef_idx;
    logic signed [COEFF_WIDTH-1:0]  coef;
    logic signed [INPUT_WIDTH-1:0]  x_sel;
    logic signed [ACC_WIDTH-1:0]    acc_sum;

    // Phase p uses every INTERP-th prototype coefficient starting at h[p].
    assign coef_sum = 32'(tap_q) * INTERP + 32'(phase_q);
    assign coef_idx = IDX_W'(coef_sum);
    assign coef     = COEFFS[coef_idx];
    assign x_sel    = x_q[tap_q];

    fir_mac_unit #(
        .INPUT_WIDTH (INPUT_WIDTH),
        .COEFF_WIDTH (COEFF_WIDTH),
        .ACC_WIDTH   (ACC_WIDTH)
    ) u_mac (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (mac_clr),
        .en      (mac_en),
        .x       (x_sel),
        .h       (coef),
        .acc_sum (acc_sum)
    );

    always_comb begin
        state_d   = state_q;
        tap_d     = tap_q;
        phase_d   = phase_q;
        dout_d    = dout_q;
        valid_d   = valid_q;
        ready_in  = 1'b0;
        shift_en  = 1'b0;
        mac_clr   = 1'b0;
        mac_en    = 1'b0;

        unique case (state_q)
            StIdle: begin
                // Held low while reset is asserted even though the state is already idle.
                ready_in = rst_n;
                if (valid_in) begin
                    shift_en = 1'b1;
                    mac_clr  = 1'b1;
                    tap_d    = '0;
                    phase_d  = '0;
                    state_d  = StMac;
                end
            end
            StMac: begin
                mac_en = 1'b1;
                if (tap_q == TAP_W'(P - 1)) begin
                    dout_d  = OUTPUT_WIDTH'(scale_out(64'(acc_sum), ACC_WIDTH, OUTPUT_WIDTH));
                    valid_d = 1'b1;
                    state_d = StOut;
                end else begin
                    tap_d = tap_q + TAP_W'(1);
                end
            end
            StOut: begin
                if (ready_out) begin
                    valid_d = 1'b0;
                    if (phase_q == PH_W'(INTERP - 1)) begin
                        state_d = StIdle;
                    end else begin
                        phase_d = phase_q + PH_W'(1);
                        tap_d   = '0;
                        mac_clr = 1'b1;
                        state_d = StMac;
                    end
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            tap_q   <= '0;
            phase_q <= '0;
            dout_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            tap_q   <= tap_d;
            phase_q <= phase_d;
            dout_q  <= dout_d;
            valid_q <= valid_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < P; k++) begin
                x_q[k] <= '0;
            end
        end else if (shift_en) begin
            x_q[0] <= din;
            for (int k = 1; k < P; k++) begin
                x_q[k] <= x_q[k-1];
            end
        end
    end

    assign dout      = dout_q;
    assign valid_out = valid_q;

endmodule

// File: tb/tb_fir_interpolator_serial.sv
// Scoreboard bench: a polyphase reference model queues expected outputs per accepted input,
// a negedge monitor pops and compares whenever an output handshake is presented.
module tb_fir_interpolator_serial;

    localparam int IW    = 16;
    localparam int CW    = 8;
    localparam int OW    = 25;
    localparam int OW_T  = 20;
    localparam int L     = 4;
    localparam int NT    = 8;
    localparam int P     = NT / L;
    localparam int ACC_W = IW + CW + 1;
    localparam int SPACING = 1 + L * (P + 1);
    localparam logic signed [CW-1:0] H [NT] = '{8'sd1, 8'sd2, 8'sd3, 8'sd4,
                                                8'sd5, 8'sd6, 8'sd7, 8'sd8};

    logic            clk = 1'b0;
    logic            rst_n = 1'b1;
    logic            valid_in = 1'b0;
    logic            ready_out = 1'b0;
    logic [IW-1:0]   din = '0;
    logic            ready_in, valid_out;
    logic [OW-1:0]   dout;
    logic            ready_in_t, valid_out_t;
    logic [OW_T-1:0] dout_t;

    int     total = 0;
    int     bad = 0;
    longint cyc = 0;
    longint exp_q [$];
    longint exp_t_q [$];
    longint hist [P];
    bit     stall_prev = 1'b0;
    bit     vo_prev = 1'b0;
    bit     lat_pending = 1'b0;
    bit     tput_chk = 1'b0;
    bit     rand_rdy = 1'b0;
    longint held = 0;
    longint held_t = 0;
    longint acc_edge = 0;
    longint last_acc = -1;

    fir_interpolator_serial #(
        .INPUT_WIDTH (IW), .COEFF_WIDTH (CW), .OUTPUT_WIDTH (OW),
        .INTERP (L), .NUM_TAPS (NT), .COEFFS (H)
    ) dut (
        .clk (clk), .rst_n (rst_n), .valid_in (valid_in), .ready_in (ready_in),
        .din (din), .valid_out (valid_out), .ready_out (ready_out), .dout (dout)
    );

    fir_interpolator_serial #(
        .INPUT_WIDTH (IW), .COEFF_WIDTH (CW), .OUTPUT_WIDTH (OW_T),
        .INTERP (L), .NUM_TAPS (NT), .COEFFS (H)
    ) dut_t (
        .clk (clk), .rst_n (rst_n), .valid_in (valid_in), .ready_in (ready_in_t),
        .din (din), .valid_out (valid_out_t), .ready_out (ready_out), .dout (dout_t)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        if (rand_rdy) begin
            #1 ready_out = ($urandom_range(0, 3) != 0);
        end
    end

    task automatic check(input string name, input longint got, input longint want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d", name, got, want);
        end
    endtask

    // Output phase p = sum_k x[k] * h[k*L + p], with x[0] the newest sample.
    function automatic void push_model(input logic signed [IW-1:0] d);
        longint s;
        for (int k = P - 1; k > 0; k--) hist[k] = hist[k-1];
        hist[0] = longint'(d);
        for (int p = 0; p < L; p++) begin
            s = 0;
            for (int k = 0; k < P; k++) s += hist[k] * longint'(H[k*L + p]);
            exp_q.push_back(s);
            exp_t_q.push_back(s >>> (ACC_W - OW_T));
        end
    endfunction

    task automatic send(input logic [IW-1:0] d);
        bit done;
        done = 1'b0;
        valid_in = 1'b1;
        din = d;
        for (int i = 0; i < 400 && !done; i++) begin
            @(negedge clk);
            if (ready_in) begin
                if (tput_chk && last_acc >= 0) check("accept_spacing", cyc + 1 - last_acc, SPACING);
                last_acc = cyc + 1;
                acc_edge = cyc + 1;
                lat_pending = 1'b1;
                push_model(d);
                done = 1'b1;
            end
        end
        if (!done) begin
            total++;
            bad++;
            $display("FAIL accept_timeout got=ready_in_low want=ready_in_high");
        end
        @(posedge clk);
        #1 valid_in = 1'b0;
    endtask

    task automatic do_reset(input int cycles);
        rst_n = 1'b0;
        valid_in = 1'b0;
        #1;
        check("rst_valid_out", longint'(valid_out), 0);
        check("rst_ready_in", longint'(ready_in), 0);
        check("rst_dout", longint'($signed(dout)), 0);
        check("rst_valid_out_t", longint'(valid_out_t), 0);
        exp_q.delete();
        exp_t_q.delete();
        for (int k = 0; k < P; k++) hist[k] = 0;
        lat_pending = 1'b0;
        stall_prev = 1'b0;
        repeat (cycles) @(posedge clk);
        #1 rst_n = 1'b1;
        #1 check("post_rst_ready_in", longint'(ready_in), 1);
    endtask

    task automatic drain();
        bit done;
        done = 1'b0;
        for (int i = 0; i < 3000 && !done; i++) begin
            @(posedge clk);
            if (exp_q.size() == 0) done = 1'b1;
        end
        if (!done) begin
            total++;
            bad++;
            $display("FAIL drain_timeout got=%0d want=0 pending outputs", exp_q.size());
        end
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin : monitor
        longint w, wt;
        if (!rst_n) begin
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) begin
                check("hold_valid_out", longint'(valid_out), 1);
                check("hold_dout", longint'($signed(dout)), held);
                check("hold_dout_t", longint'($signed(dout_t)), held_t);
                check("hold_ready_in", longint'(ready_in), 0);
            end
            if (valid_out && !vo_prev && lat_pending) begin
                check("latency", cyc - acc_edge, P);
                lat_pending = 1'b0;
            end
            if (valid_out && ready_out) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_out got=%0d want=no_output", $signed(dout));
                end else begin
                    w  = exp_q.pop_front();
                    wt = exp_t_q.pop_front();
                    check("dout", longint'($signed(dout)), w);
                    check("valid_out_t", longint'(valid_out_t), 1);
                    check("dout_trunc", longint'($signed(dout_t)), wt);
                end
            end
            stall_prev = valid_out && !ready_out;
            held   = longint'($signed(dout));
            held_t = longint'($signed(dout_t));
        end
        vo_prev = valid_out;
    end

    initial begin
        #1;
        do_reset(3);
        ready_out = 1'b1;

        // Impulse, then step with spacing check, then negative impulse.
        send(16'd1); send(16'd0); send(16'd0);
        tput_chk = 1'b1;
        last_acc = -1;
        repeat (5) send(16'd100);
        tput_chk = 1'b0;
        send(16'hFFFF); send(16'd0); send(16'd0);
        drain();

        // Backpressure on the second output phase, with ignored valid_in pulses.
        ready_out = 1'b0;
        send(16'd1);
        for (int i = 0; i < 50; i++) begin
            @(posedge clk);
            #1;
            if (valid_out) break;
        end
        ready_out = 1'b1;
        @(posedge clk);
        #1 ready_out = 1'b0;
        repeat (8) begin
            @(posedge clk);
            #1;
            valid_in = 1'($urandom_range(0, 1));
            din = IW'($urandom);
        end
        valid_in = 1'b0;
        ready_out = 1'b1;
        drain();

        // Reset during the phase-2 MAC, then an impulse must see clean history.
        send(16'd1);
        repeat (7) @(posedge clk);
        #1;
        do_reset(2);
        send(16'd1); send(16'd0); send(16'd0);
        drain();

        // Random samples with random downstream backpressure.
        rand_rdy = 1'b1;
        repeat (40) begin
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
            send(IW'($urandom));
        end
        drain();
        rand_rdy = 1'b0;
        repeat (2) @(posedge clk);
        check("final_queue_empty", longint'(exp_q.size()), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog got=running want=finished");
        $fatal(1, "watchdog expired");
    end

endmodule
